// File: rtl/dcs_pkg.sv
// Shared definitions for the DCSformer host-side controller.
//   dcs_state_t    : host controller FSM states
//   DCS_ROWS/COLS  : matrix geometry (also weight and result counts)
//   DCS_WADDR_BASE : first cfg address of the weight buffer
//   dcs_word_t     : one 32-bit result word
package dcs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND_I  = 3'd1,
    ST_WAIT_WR = 3'd2,
    ST_SEND_W  = 3'd3,
    ST_WAIT_O  = 3'd4
  } dcs_state_t;

  localparam int DCS_ROWS       = 8;
  localparam int DCS_COLS       = 16;
  localparam int DCS_WADDR_BASE = 128;

  typedef logic [31:0] dcs_word_t;

endpackage

// File: rtl/dcs_host_timeout.sv
// Wait-state timeout counter shared by WAIT_WR and WAIT_O.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : hold count at zero (asserted whenever not waiting)
//   en         : count one wait cycle
//   expired    : current wait cycle is the TIMEOUT_CYC-th one
module dcs_host_timeout #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  // cnt holds the number of wait cycles already completed, so the cycle
  // that would complete the TIMEOUT_CYC-th one is the expiring cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en && cnt != CW'(TIMEOUT_CYC)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = en && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/dcs_host_ctrl.sv
// Host-side initiator for the DCSformer i/w/o streaming interface.
// Holds an 8x16 byte matrix and 8 weight bytes written via cfg_*; on start
// streams the matrix on i_*, waits for w_ready, streams weights on w_*, and
// captures eight 32-bit results from o_* into a readable result buffer.
//   cfg_we/cfg_addr/cfg_wdata : buffer writes (0..127 matrix, 128..135 weights), IDLE only
//   start                     : run one transaction (ignored while busy)
//   busy, done, err           : status; err is sticky until the next accepted start
//   res_addr/res_data         : combinational result read
//   i_valid/i_data            : matrix byte stream
//   w_ready, w_valid/w_data   : weight handshake and stream
//   o_valid/o_data            : result stream
// Build option: DCS_HOST_ROWGAP_EN inserts one idle cycle after each matrix
// row except the last.
module dcs_host_ctrl
  import dcs_pkg::*;
#(
  parameter int ROWS        = DCS_ROWS,
  parameter int COLS        = DCS_COLS,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_we,
  input  logic [7:0]  cfg_addr,
  input  logic [7:0]  cfg_wdata,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [2:0]  res_addr,
  output logic [31:0] res_data,
  output logic        i_valid,
  output logic [7:0]  i_data,
  input  logic        w_ready,
  output logic        w_valid,
  output logic [7:0]  w_data,
  input  logic        o_valid,
  input  logic [31:0] o_data
);

  localparam int MLEN = ROWS * COLS;
  localparam int MIW  = $clog2(MLEN);
  localparam int RIW  = $clog2(ROWS);
`ifdef DCS_HOST_ROWGAP_EN
  localparam int CIW  = $clog2(COLS);
`endif

  logic [7:0] mat_buf [MLEN];
  logic [7:0] wt_buf  [ROWS];
  dcs_word_t  res_buf [ROWS];

  dcs_state_t     state;
  logic [MIW-1:0] i_idx;
  logic [RIW-1:0] w_idx;
  logic [RIW-1:0] r_idx;
`ifdef DCS_HOST_ROWGAP_EN
  logic           row_gap;
`endif

  logic       tmo_clr;
  logic       tmo_expired;
  logic [7:0] cfg_woff;

  // Counter is held clear outside the wait states, so it starts at zero on
  // each entry to WAIT_WR or WAIT_O.
  assign tmo_clr = !(state == ST_WAIT_WR || state == ST_WAIT_O);

  dcs_host_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmo_clr),
    .en     (!tmo_clr),
    .expired(tmo_expired)
  );

  assign cfg_woff = cfg_addr - 8'(DCS_WADDR_BASE);

  // Data buffers are not reset; writes are dropped outside IDLE.
  always_ff @(posedge clk) begin
    if (cfg_we && state == ST_IDLE) begin
      if (cfg_addr < 8'(MLEN)) begin
        mat_buf[cfg_addr[MIW-1:0]] <= cfg_wdata;
      end else if (cfg_addr >= 8'(DCS_WADDR_BASE) && cfg_woff < 8'(ROWS)) begin
        wt_buf[cfg_woff[RIW-1:0]] <= cfg_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      i_valid <= 1'b0;
      i_data  <= '0;
      w_valid <= 1'b0;
      w_data  <= '0;
      i_idx   <= '0;
      w_idx   <= '0;
      r_idx   <= '0;
`ifdef DCS_HOST_ROWGAP_EN
      row_gap <= 1'b0;
`endif
      for (int unsigned k = 0; k < ROWS; k++) begin
        res_buf[k] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_SEND_I;
            busy    <= 1'b1;
            err     <= 1'b0;
            i_idx   <= '0;
            i_valid <= 1'b1;
            i_data  <= mat_buf[0];
`ifdef DCS_HOST_ROWGAP_EN
            row_gap <= 1'b0;
`endif
          end
        end

        // i_idx is the byte currently on the bus (or just sent, in a gap).
        ST_SEND_I: begin
          if (i_idx == MIW'(MLEN - 1)) begin
            i_valid <= 1'b0;
            i_data  <= '0;
            state   <= ST_WAIT_WR;
          end
`ifdef DCS_HOST_ROWGAP_EN
          else if (!row_gap && i_idx[CIW-1:0] == '1) begin
            row_gap <= 1'b1;
            i_valid <= 1'b0;
            i_data  <= '0;
          end else begin
            row_gap <= 1'b0;
            i_valid <= 1'b1;
            i_idx   <= i_idx + 1'b1;
            i_data  <= mat_buf[i_idx + 1'b1];
          end
`else
          else begin
            i_idx  <= i_idx + 1'b1;
            i_data <= mat_buf[i_idx + 1'b1];
          end
`endif
        end

        ST_WAIT_WR: begin
          if (w_ready) begin
            state   <= ST_SEND_W;
            w_idx   <= '0;
            w_valid <= 1'b1;
            w_data  <= wt_buf[0];
          end else if (tmo_expired) begin
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        ST_SEND_W: begin
          if (w_idx == RIW'(ROWS - 1)) begin
            w_valid <= 1'b0;
            w_data  <= '0;
            r_idx   <= '0;
            state   <= ST_WAIT_O;
          end else begin
            w_idx  <= w_idx + 1'b1;
            w_data <= wt_buf[w_idx + 1'b1];
          end
        end

        ST_WAIT_O: begin
          if (o_valid) begin
            res_buf[r_idx] <= o_data;
            if (r_idx == RIW'(ROWS - 1)) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else if (tmo_expired) begin
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign res_data = res_buf[res_addr];

endmodule

// File: tb/tb_dcs_host_ctrl.sv
// Self-checking bench for dcs_host_ctrl. The bench plays the accelerator:
// it collects the i/w streams, answers w_ready after a random delay and
// returns results computed from what it received, with random o_valid gaps.
// Expectations come from a reference of the loaded buffers and the
// transaction rules (stream contents, gap positions, timeout length, result
// buffer contents after normal end, abort and reset).
module tb_dcs_host_ctrl;

  localparam int TMO = 1023;

  logic        clk = 1'b0;
  logic        rst_n, cfg_we, start;
  logic [7:0]  cfg_addr, cfg_wdata;
  logic        busy, done, err;
  logic [2:0]  res_addr;
  logic [31:0] res_data;
  logic        i_valid, w_ready, w_valid, o_valid;
  logic [7:0]  i_data, w_data;
  logic [31:0] o_data;

  always #5 clk = ~clk;

  dcs_host_ctrl #(.ROWS(8), .COLS(16), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .start(start), .busy(busy), .done(done),
    .err(err), .res_addr(res_addr), .res_data(res_data),
    .i_valid(i_valid), .i_data(i_data), .w_ready(w_ready),
    .w_valid(w_valid), .w_data(w_data), .o_valid(o_valid), .o_data(o_data)
  );

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [7:0]  ref_mat [128];
  logic [7:0]  ref_wt  [8];
  logic [31:0] buf_model [8];

  // Observations from the last transaction
  logic [7:0] obs_i [$];
  logic [7:0] obs_w [$];
  int         obs_gaps [$];
  int         done_cnt, wait_wr_cyc, w_bursts, idle_bad, done_busy_bad;
  bit         timed_out;

  function automatic logic [31:0] model_result(input int r);
    logic [31:0] s = 0;
    for (int c = 0; c < 16; c++) s += 32'(ref_mat[r*16+c]) * 32'(ref_wt[c%8]);
    return s;
  endfunction

  function automatic logic [31:0] acc_word(input int r);
    logic [31:0] s = 0;
    for (int c = 0; c < 16; c++)
      if (r*16+c < obs_i.size() && (c%8) < obs_w.size())
        s += 32'(obs_i[r*16+c]) * 32'(obs_w[c%8]);
    return s;
  endfunction

  task automatic cfg_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
  endtask

  task automatic load_buffers();
    for (int a = 0; a < 128; a++) cfg_write(8'(a), ref_mat[a]);
    for (int j = 0; j < 8; j++) cfg_write(8'(128 + j), ref_wt[j]);
    // out-of-range addresses must not alias into either buffer
    for (int a = 136; a < 144; a++) cfg_write(8'(a), 8'($urandom));
    cfg_write(8'hFF, 8'($urandom));
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Runs one transaction acting as the accelerator. Returns 20 cycles after
  // the first done, or right after driving rst_n low once 4 weights are seen.
  task automatic run_txn(input bit wr_en, input int wr_delay, input int ogap,
                         input int n_res, input int inject_cyc, input bit rst_in_w);
    logic [31:0] oq [$];
    int  wr_cnt = 0, phase = 0, post = -1;
    bit  wr_armed = 0, wr_sent = 0, prev_w = 0;
    obs_i.delete(); obs_w.delete(); obs_gaps.delete();
    done_cnt = 0; wait_wr_cyc = 0; w_bursts = 0; idle_bad = 0; done_busy_bad = 0;
    timed_out = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      phase++;
      if (i_valid) obs_i.push_back(i_data);
      else begin
        if (i_data != 8'h00) idle_bad++;
        if (obs_i.size() > 0 && obs_i.size() < 128) obs_gaps.push_back(phase);
      end
      if (w_valid) begin
        obs_w.push_back(w_data);
        if (!prev_w) w_bursts++;
      end else if (w_data != 8'h00) idle_bad++;
      if (done) begin
        done_cnt++;
        if (busy) done_busy_bad++;
        if (post < 0) post = 20;
      end
      if (obs_i.size() == 128 && !i_valid && busy && obs_w.size() == 0 && !w_valid)
        wait_wr_cyc++;

      start = 1'b0; cfg_we = 1'b0; w_ready = 1'b0; o_valid = 1'b0; o_data = $urandom;
      if (rst_in_w && obs_w.size() == 4) begin
        rst_n = 1'b0;
        timed_out = 1'b0;
        return;
      end
      if (cyc == inject_cyc) begin
        cfg_we = 1'b1; cfg_addr = 8'h00; cfg_wdata = 8'hFF; start = 1'b1;
      end
      // stray handshakes while the matrix is streaming must be ignored
      if (wr_en && i_valid && obs_i.size() < 100 && ($urandom % 8) == 0) w_ready = 1'b1;
      if (i_valid && ($urandom % 8) == 0) o_valid = 1'b1;
      if (wr_en && !wr_armed && obs_i.size() == 128 && !i_valid) begin
        wr_armed = 1'b1; wr_cnt = wr_delay;
      end
      if (wr_armed && !wr_sent) begin
        if (wr_cnt == 0) begin w_ready = 1'b1; wr_sent = 1'b1; end
        else wr_cnt--;
      end
      if (prev_w && !w_valid)
        for (int r = 0; r < n_res; r++) oq.push_back(acc_word(r));
      if (oq.size() > 0 && ($urandom % (ogap + 1)) == 0) begin
        o_valid = 1'b1; o_data = oq.pop_front();
      end
      prev_w = w_valid;
      if (post > 0) begin
        post--;
        if (post == 0) begin timed_out = 1'b0; break; end
      end
    end
    start = 1'b0; w_ready = 1'b0; o_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err, i_valid, w_valid} !== 5'b0 || i_data !== 8'h00 || w_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b iv=%b wv=%b id=%h wd=%h, want all 0",
               busy, done, err, i_valid, w_valid, i_data, w_data);
    end
    for (int r = 0; r < 8; r++) begin
      buf_model[r] = 32'h0;
      res_addr = 3'(r); #1;
      checks++;
      if (res_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_result[%0d]: got %h want 0", r, res_data);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // mode 0: identity matrix, weights 1..8; mode 1: random data;
  // mode 2: reuse buffers, inject a cfg write and a second start mid-run
  task automatic test_transfer(input int mode);
    int exp_gaps [$];
    int bad = 0;
    if (mode == 0) begin
      for (int a = 0; a < 128; a++) ref_mat[a] = ((a / 16) == (a % 16)) ? 8'd1 : 8'd0;
      for (int j = 0; j < 8; j++) ref_wt[j] = 8'(j + 1);
      load_buffers();
    end else if (mode == 1) begin
      for (int a = 0; a < 128; a++) ref_mat[a] = 8'($urandom);
      for (int j = 0; j < 8; j++) ref_wt[j] = 8'($urandom);
      load_buffers();
    end
    run_txn(1'b1, $urandom_range(0, 5), $urandom_range(0, 3), 8, (mode == 2) ? 40 : -1, 1'b0);
`ifdef DCS_HOST_ROWGAP_EN
    for (int k = 1; k < 8; k++) exp_gaps.push_back(17 * k);
`endif
    checks++;
    if (timed_out) begin errors++; $display("FAIL xfer_timeout: no done within cycle budget (mode %0d)", mode); end
    checks++;
    if (obs_i.size() != 128) begin errors++; $display("FAIL i_count: got %0d bytes want 128", obs_i.size()); end
    for (int a = 0; a < 128 && a < obs_i.size(); a++) if (obs_i[a] !== ref_mat[a]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL i_bytes: %0d wrong bytes, byte0 got %h want %h", bad, obs_i[0], ref_mat[0]); end
    bad = 0;
    if (obs_gaps.size() != exp_gaps.size()) bad = 1;
    else for (int k = 0; k < exp_gaps.size(); k++) if (obs_gaps[k] != exp_gaps[k]) bad = 1;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL i_gaps: got %0d gaps want %0d", obs_gaps.size(), exp_gaps.size()); end
    bad = 0;
    for (int j = 0; j < 8 && j < obs_w.size(); j++) if (obs_w[j] !== ref_wt[j]) bad++;
    checks++;
    if (obs_w.size() != 8 || w_bursts != 1 || bad != 0) begin
      errors++;
      $display("FAIL w_stream: got %0d bytes in %0d bursts, %0d wrong, want 8 in 1, 0 wrong", obs_w.size(), w_bursts, bad);
    end
    checks++;
    if (idle_bad != 0) begin errors++; $display("FAIL idle_data: %0d cycles nonzero data while not valid, want 0", idle_bad); end
    checks++;
    if (done_cnt != 1 || done_busy_bad != 0) begin
      errors++; $display("FAIL done_pulse: got %0d done cycles (%0d with busy) want 1 (0)", done_cnt, done_busy_bad);
    end
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL xfer_status: got err=%b busy=%b want 0 0", err, busy); end
    for (int r = 0; r < 8; r++) begin
      buf_model[r] = model_result(r);
      res_addr = 3'(r); #1;
      checks++;
      if (res_data !== buf_model[r]) begin
        errors++; $display("FAIL result[%0d]: got %h want %h (mode %0d)", r, res_data, buf_model[r], mode);
      end
    end
    if (mode == 0) begin
      res_addr = 3'd7; #1;
      checks++;
      if (res_data !== 32'd8) begin errors++; $display("FAIL identity_result7: got %0d want 8", res_data); end
    end
  endtask

  task automatic test_timeout_wr();
    run_txn(1'b0, 0, 0, 8, -1, 1'b0);
    checks++;
    if (timed_out) begin errors++; $display("FAIL wr_timeout_done: no done within cycle budget"); end
    checks++;
    if (wait_wr_cyc != TMO) begin errors++; $display("FAIL wr_wait_cycles: got %0d want %0d", wait_wr_cyc, TMO); end
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || done_cnt != 1) begin
      errors++; $display("FAIL wr_timeout_status: got err=%b busy=%b dones=%0d want 1 0 1", err, busy, done_cnt);
    end
    checks++;
    if (obs_w.size() != 0 || obs_i.size() != 128) begin
      errors++; $display("FAIL wr_timeout_streams: got %0d i bytes, %0d w bytes want 128, 0", obs_i.size(), obs_w.size());
    end
    for (int r = 0; r < 8; r++) begin
      res_addr = 3'(r); #1;
      checks++;
      if (res_data !== buf_model[r]) begin errors++; $display("FAIL wr_timeout_keep[%0d]: got %h want %h", r, res_data, buf_model[r]); end
    end
  endtask

  task automatic test_timeout_o();
    for (int a = 0; a < 128; a++) ref_mat[a] = 8'($urandom);
    for (int j = 0; j < 8; j++) ref_wt[j] = 8'($urandom);
    load_buffers();
    run_txn(1'b1, 2, 1, 3, -1, 1'b0);
    checks++;
    if (timed_out || err !== 1'b1 || busy !== 1'b0 || done_cnt != 1) begin
      errors++; $display("FAIL o_timeout_status: got err=%b busy=%b dones=%0d want 1 0 1", err, busy, done_cnt);
    end
    for (int r = 0; r < 3; r++) buf_model[r] = model_result(r);
    for (int r = 0; r < 8; r++) begin
      res_addr = 3'(r); #1;
      checks++;
      if (res_data !== buf_model[r]) begin errors++; $display("FAIL o_timeout_partial[%0d]: got %h want %h", r, res_data, buf_model[r]); end
    end
  endtask

  task automatic test_reset_mid();
    run_txn(1'b1, 1, 0, 8, -1, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (timed_out || w_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || w_data !== 8'h00) begin
      errors++; $display("FAIL mid_reset: got wv=%b busy=%b done=%b wd=%h want 0 0 0 00", w_valid, busy, done, w_data);
    end
    for (int r = 0; r < 8; r++) begin
      buf_model[r] = 32'h0;
      res_addr = 3'(r); #1;
      checks++;
      if (res_data !== 32'h0) begin errors++; $display("FAIL mid_reset_result[%0d]: got %h want 0", r, res_data); end
    end
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; start = 1'b0;
    res_addr = '0; w_ready = 1'b0; o_valid = 1'b0; o_data = '0;
    test_reset();
    test_transfer(0);
    repeat (3) test_transfer(1);
    test_timeout_wr();
    test_transfer(2);
    test_transfer(2);
    test_timeout_o();
    test_reset_mid();
    test_transfer(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
